// File: rtl/alu_issue_if.sv
// Fetch-side instruction handshake between the fetch unit and alu_issue.
interface alu_issue_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;

   modport master (output instr_valid, output instr_data, input instr_ready);
   modport slave  (input instr_valid, input instr_data, output instr_ready);
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback sequencer in front of a combinational ALU.
// One instruction in flight: IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE.
// Only OP_IMM and OP opcodes are executed; anything else pulses illegal.
module alu_issue #(
   parameter bit BYTE_SWAP = 1'b1,
   parameter bit DBG_EN    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   alu_issue_if.slave  fetch,
   output logic [31:0] alu_instruction,
   output logic [31:0] alu_op_a,
   output logic [31:0] alu_op_b,
   input  logic [31:0] alu_out,
   output logic        retire_valid,
   output logic [4:0]  retire_rd,
   output logic        illegal,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic [31:0] alu_instr_q, alu_instr_d;
   logic [31:0] res_q, res_d;
   logic        illegal_q, illegal_d;
   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];

   logic [31:0] fetch_word;
   logic [4:0]  rd;
   logic [6:0]  opcode;

   // Memory byte order reversed so ir[6:0] is the opcode.
   assign fetch_word = BYTE_SWAP ? {fetch.instr_data[7:0],   fetch.instr_data[15:8],
                                    fetch.instr_data[23:16], fetch.instr_data[31:24]}
                                 : fetch.instr_data;
   assign rd     = ir_q[11:7];
   assign opcode = ir_q[6:0];

   // Next-state, datapath and register-file write decisions.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      alu_instr_d = alu_instr_q;
      res_d       = res_q;
      illegal_d   = 1'b0;
      rf_d        = rf_q;
      case (state_q)
         IDLE: begin
            if (fetch.instr_valid && ready_q) begin
               ir_d    = fetch_word;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (opcode == OPC_OP_IMM || opcode == OPC_OP) begin
               alu_instr_d = ir_q;
               op_a_d      = rf_q[ir_q[19:15]];
               // OP_IMM carries its immediate in the instruction word itself.
               op_b_d      = (opcode == OPC_OP) ? rf_q[ir_q[24:20]] : 32'h0;
               state_d     = EXECUTE;
            end else begin
               illegal_d = 1'b1;
               state_d   = IDLE;
            end
         end
         EXECUTE: begin
            res_d   = alu_out;
            state_d = WRITEBACK;
         end
         WRITEBACK: begin
            if (rd != 5'd0) rf_d[rd] = res_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Registered ready keeps it low until the first edge after reset.
      ready_d = (state_d == IDLE);
   end

   // Control and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         ir_q        <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         alu_instr_q <= '0;
         res_q       <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         ir_q        <= ir_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         alu_instr_q <= alu_instr_d;
         res_q       <= res_d;
         illegal_q   <= illegal_d;
      end
   end

   // Register file; x0 is never written so it reads back as zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
      end
   end

   assign fetch.instr_ready = ready_q;
   assign alu_instruction   = alu_instr_q;
   assign alu_op_a          = op_a_q;
   assign alu_op_b          = op_b_q;
   assign illegal           = illegal_q;
   assign retire_valid      = (state_q == WRITEBACK);
   assign retire_rd         = retire_valid ? rd : 5'd0;
   assign dbg_data          = (DBG_EN && dbg_addr != 5'd0) ? rf_q[dbg_addr] : 32'h0;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized scoreboard bench for alu_issue with an RV32I integer model.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] alu_instruction, alu_op_a, alu_op_b, alu_out;
   logic        retire_valid, illegal;
   logic [4:0]  retire_rd, dbg_addr;
   logic [31:0] dbg_data;

   alu_issue_if fif ();

   alu_issue dut (
      .clk(clk), .reset(reset), .fetch(fif),
      .alu_instruction(alu_instruction), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
      .alu_out(alu_out), .retire_valid(retire_valid), .retire_rd(retire_rd),
      .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          ill;
      logic [4:0]  rd;
      logic [31:0] instr, a, b, dbg_exp;
      int          exp_cyc;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] model_rf [32];

   logic [4:0]  mon_addr = 5'd0;
   logic [4:0]  sweep_addr = 5'd0;
   bit          sweep = 1'b0;
   bit          pend_dbg = 1'b0;
   logic [31:0] pend_val;
   logic [4:0]  pend_addr;
   assign dbg_addr = sweep ? sweep_addr : mon_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RV32I integer semantics; for OP_IMM the operand b is the sign-extended immediate.
   function automatic logic [31:0] rv_exec(input logic [31:0] ins, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0]        y, r;
      logic signed [31:0] sa, sy;
      logic [4:0]         sh;
      bit                 is_op;
      is_op = (ins[6:0] == 7'h33);
      y     = is_op ? b : {{20{ins[31]}}, ins[31:20]};
      sh    = y[4:0];
      sa    = a;
      sy    = y;
      case (ins[14:12])
         3'd0: r = (is_op && ins[30]) ? a - y : a + y;
         3'd1: r = a << sh;
         3'd2: r = (sa < sy) ? 32'd1 : 32'd0;
         3'd3: r = (a < y) ? 32'd1 : 32'd0;
         3'd4: r = a ^ y;
         3'd5: if (ins[30]) r = sa >>> sh; else r = a >> sh;
         3'd6: r = a | y;
         default: r = a & y;
      endcase
      return r;
   endfunction

   // The ALU the sequencer drives.
   always_comb alu_out = rv_exec(alu_instruction, alu_op_a, alu_op_b);

   function automatic logic [31:0] swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   // Architectural effect of one accepted word, plus what the bench expects to see.
   function automatic void model_issue(input logic [31:0] w, input int acc);
      exp_t e;
      e.instr = w;
      e.rd    = w[11:7];
      if (w[6:0] != 7'h13 && w[6:0] != 7'h33) begin
         e.ill     = 1'b1;
         e.a       = '0;
         e.b       = '0;
         e.exp_cyc = acc + 1;
      end else begin
         e.ill     = 1'b0;
         e.a       = model_rf[w[19:15]];
         e.b       = (w[6:0] == 7'h33) ? model_rf[w[24:20]] : 32'h0;
         e.exp_cyc = acc + 2;
         if (e.rd != 5'd0) model_rf[e.rd] = rv_exec(w, e.a, e.b);
      end
      e.dbg_exp = model_rf[e.rd];
      sb.push_back(e);
   endfunction

   // Monitor: pops one expectation per retire/illegal pulse, then checks the rd readback.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (pend_dbg) begin
            check($sformatf("dbg_x%0d", pend_addr), dbg_data, pend_val);
            pend_dbg = 1'b0;
         end
         if (retire_valid || illegal) begin
            if (sb.size() == 0) begin
               check("unexpected_pulse", {30'd0, retire_valid, illegal}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("illegal_flag", {31'd0, illegal}, {31'd0, e.ill});
               check("retire_flag", {31'd0, retire_valid}, {31'd0, !e.ill});
               check("pulse_cycle", cyc, e.exp_cyc);
               if (!e.ill) begin
                  check("retire_rd", {27'd0, retire_rd}, {27'd0, e.rd});
                  check("alu_instruction", alu_instruction, e.instr);
                  check("alu_op_a", alu_op_a, e.a);
                  check("alu_op_b", alu_op_b, e.b);
               end
               mon_addr  = e.rd;
               pend_addr = e.rd;
               pend_val  = e.dbg_exp;
               pend_dbg  = 1'b1;
            end
         end
      end
   end

   // Called at a negedge; valid stays high on return so calls can be back to back.
   task automatic send(input logic [31:0] w, input bit track, output int acc);
      int n = 0;
      acc = -1;
      fif.instr_valid = 1'b1;
      fif.instr_data  = swap32(w);
      while (!fif.instr_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!fif.instr_ready) begin
         check("accept_timeout", {31'd0, fif.instr_ready}, 32'd1);
         fif.instr_valid = 1'b0;
      end else begin
         @(posedge clk);
         @(negedge clk);
         acc = cyc;
         if (track) model_issue(w, acc);
      end
   endtask

   task automatic drain();
      int n = 0;
      fif.instr_valid = 1'b0;
      while ((sb.size() != 0 || pend_dbg) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", sb.size(), 32'd0);
      @(negedge clk);
   endtask

   task automatic sweep_rf();
      sweep = 1'b1;
      for (int a = 0; a < 32; a++) begin
         sweep_addr = a[4:0];
         #1;
         check($sformatf("sweep_x%0d", a), dbg_data, model_rf[a]);
         @(negedge clk);
      end
      sweep = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [6:0]  bad [5];
      bad = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};
      f3  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0)
         return {25'($urandom), bad[$urandom_range(0, 4)]};
      if ($urandom_range(0, 1) == 0) begin
         return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                      5'($urandom), 5'($urandom), f3, 5'($urandom));
      end
      imm = 12'($urandom);
      if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
      if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
      return enc_i(imm, 5'($urandom), f3, 5'($urandom));
   endfunction

   initial begin
      int a0, a1, a2;
      reset = 1'b1;
      fif.instr_valid = 1'b0;
      fif.instr_data  = '0;
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
      #1;
      check("rst_ready", {31'd0, fif.instr_ready}, 32'd0);
      check("rst_alu_instr", alu_instruction, 32'd0);
      check("rst_op_a", alu_op_a, 32'd0);
      check("rst_op_b", alu_op_b, 32'd0);
      check("rst_retire", {26'd0, retire_valid, retire_rd}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1 check("ready_before_edge", {31'd0, fif.instr_ready}, 32'd0);
      @(negedge clk);
      check("ready_after_edge", {31'd0, fif.instr_ready}, 32'd1);

      // Directed sequence.
      send(32'h00100093, 1'b1, a0);                         // ADDI x1,x0,1
      send(enc_i(12'hFFF, 5'd0, 3'd0, 5'd2), 1'b1, a0);     // ADDI x2,x0,-1
      send(enc_i(12'h000, 5'd2, 3'd2, 5'd3), 1'b1, a0);     // SLTI x3,x2,0
      send(enc_i(12'd10, 5'd0, 3'd0, 5'd1), 1'b1, a0);      // ADDI x1,x0,10
      send(enc_i(12'h806, 5'd1, 3'd4, 5'd4), 1'b1, a0);     // XORI x4,x1,0x806
      send(enc_i(12'd31, 5'd2, 3'd1, 5'd5), 1'b1, a0);      // SLLI x5,x2,31
      send(enc_i(12'd5, 5'd0, 3'd0, 5'd0), 1'b1, a0);       // ADDI x0,x0,5
      send(32'h00002083, 1'b1, a0);                         // LW -> illegal
      drain();
      check("x4_direct", model_rf[4], 32'hFFFF_F80C);
      check("x5_direct", model_rf[5], 32'h8000_0000);

      // Continuous valid: acceptances four cycles apart.
      send(enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd7), 1'b1, a0);
      send(enc_r(7'h20, 5'd1, 5'd7, 3'd0, 5'd8), 1'b1, a1);
      send(enc_r(7'h20, 5'd1, 5'd4, 3'd5, 5'd9), 1'b1, a2);
      check("b2b_gap1", a1 - a0, 32'd4);
      check("b2b_gap2", a2 - a1, 32'd4);
      drain();

      // Randomized traffic with occasional idle gaps.
      for (int k = 0; k < 60; k++) begin
         send(rand_instr(), 1'b1, a0);
         if ($urandom_range(0, 3) == 0) begin
            fif.instr_valid = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
         end
      end
      drain();
      sweep_rf();

      // Reset during EXECUTE aborts the instruction.
      send(enc_i(12'd7, 5'd0, 3'd0, 5'd6), 1'b0, a0);
      fif.instr_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
      #1;
      check("midrst_ready", {31'd0, fif.instr_ready}, 32'd0);
      check("midrst_retire", {31'd0, retire_valid}, 32'd0);
      check("midrst_alu_instr", alu_instruction, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1 check("midrst_ready_pre", {31'd0, fif.instr_ready}, 32'd0);
      @(negedge clk);
      check("midrst_ready_post", {31'd0, fif.instr_ready}, 32'd1);
      repeat (4) @(negedge clk);
      sweep_rf();

      for (int k = 0; k < 10; k++) send(rand_instr(), 1'b1, a0);
      drain();
      sweep_rf();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
